// File: rtl/arcade_controls_mp.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | arcade_controls_mp: multi-player PS/2 + joystick merge, rotate, coin shaper |
// | Optional feature macro: AUTOFIRE_EN (fire B becomes autofire on fire A)     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module arcade_controls_mp #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BUTTONS = 6,
  parameter int COIN_CYCLES = 2400000
) (
  input  logic                                  clk_sys,
  input  logic                                  reset,
  input  logic                                  key_strobe,
  input  logic                                  key_pressed,
  input  logic                                  key_extended,
  input  logic [7:0]                            key_code,
  input  logic [NUM_PLAYERS*(4+NUM_BUTTONS)-1:0] joy_in,
  input  logic                                  rotate,
  input  logic [1:0]                            orientation,
  input  logic                                  joyswap,
  input  logic                                  oneplayer,
  output logic [NUM_PLAYERS-1:0]                coin,
  output logic [NUM_PLAYERS-1:0]                start,
  output logic                                  tilt,
  output logic [NUM_PLAYERS*(4+NUM_BUTTONS)-1:0] player
);

  localparam int PW = 4 + NUM_BUTTONS;
  localparam int W  = NUM_PLAYERS * PW;
  localparam int CW = $clog2(COIN_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(COIN_CYCLES - 1);

  // Key state vector layout: P1 {fireF..fireA,up,down,left,right} at 0..9,
  // P2 {fireB,fireA,up,down,left,right} at 10..15, then system keys.
  localparam int K_P1     = 0;
  localparam int K_P2     = 10;
  localparam int K_COIN1  = 16;
  localparam int K_COIN2  = 17;
  localparam int K_START1 = 18;
  localparam int K_START2 = 19;
  localparam int K_TILT   = 20;
  localparam int NK       = 21;

  typedef enum logic [0:0] {
    COIN_IDLE  = 1'b0,
    COIN_PULSE = 1'b1
  } coin_state_t;

  logic [NK-1:0] key_q, key_d;
  logic [4:0]    key_idx;
  logic          key_hit;

  always_comb begin
    key_idx = 5'd0;
    key_hit = 1'b1;
    case ({key_extended, key_code})
      9'h175: key_idx = 5'd3;
      9'h172: key_idx = 5'd2;
      9'h16B: key_idx = 5'd1;
      9'h174: key_idx = 5'd0;
      9'h014: key_idx = 5'd4;
      9'h011: key_idx = 5'd5;
      9'h029: key_idx = 5'd6;
      9'h012: key_idx = 5'd7;
      9'h01A: key_idx = 5'd8;
      9'h022: key_idx = 5'd9;
      9'h02D: key_idx = 5'd13;
      9'h02B: key_idx = 5'd12;
      9'h023: key_idx = 5'd11;
      9'h034: key_idx = 5'd10;
      9'h01C: key_idx = 5'd14;
      9'h01B: key_idx = 5'd15;
      9'h02E: key_idx = 5'd16;
      9'h036: key_idx = 5'd17;
      9'h016: key_idx = 5'd18;
      9'h01E: key_idx = 5'd19;
      9'h02C: key_idx = 5'd20;
      default: key_hit = 1'b0;
    endcase
    key_d = key_q;
    if (key_strobe && key_hit) begin
      key_d[key_idx] = key_pressed;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) key_q <= '0;
    else       key_q <= key_d;
  end

  logic [PW-1:0] key_p1, key_p2;
  assign key_p1 = key_q[K_P1 +: PW];

  // P2 has only fire A/B on the keyboard; higher fire bits stay joystick-only.
  always_comb begin
    key_p2 = '0;
    for (int b = 0; b < PW && b < 6; b++) begin
      key_p2[b] = key_q[K_P2 + b];
    end
  end

`ifdef AUTOFIRE_EN
  logic [19:0] af_cnt_q, af_cnt_d;
  logic        af_wrap;
  assign af_cnt_d = af_cnt_q + 20'd1;
  assign af_wrap  = &af_cnt_q;

  always_ff @(posedge clk_sys) begin
    if (reset) af_cnt_q <= '0;
    else       af_cnt_q <= af_cnt_d;
  end
`endif

  logic [W-1:0] joy_sw, key_flat, src_flat, mix_flat, fire_flat, rot_flat;
  logic [W-1:0] player_q;
  logic [NUM_PLAYERS-1:0] start_d, start_q, raw_coin, coin_q;
  logic tilt_q;
  logic rot_active;

  assign rot_active = rotate & orientation[0];

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    localparam int SW = (NUM_PLAYERS >= 2 && p < 2) ? 1 - p : p;

    assign joy_sw[p*PW +: PW] = joyswap ? joy_in[SW*PW +: PW] : joy_in[p*PW +: PW];

    if (p == 0) begin : g_key_p1
      assign key_flat[p*PW +: PW] = key_p1;
      assign start_d[p]           = key_q[K_START1];
      assign raw_coin[p]          = key_q[K_COIN1];
    end else if (p == 1) begin : g_key_p2
      assign key_flat[p*PW +: PW] = key_p2;
      assign start_d[p]           = key_q[K_START2];
      assign raw_coin[p]          = key_q[K_COIN2];
    end else begin : g_key_none
      assign key_flat[p*PW +: PW] = '0;
      assign start_d[p]           = 1'b0;
      assign raw_coin[p]          = 1'b0;
    end

    assign src_flat[p*PW +: PW] = joy_sw[p*PW +: PW] | key_flat[p*PW +: PW];

    if (p == 1) begin : g_mirror
      assign mix_flat[p*PW +: PW] = src_flat[p*PW +: PW] | (oneplayer ? src_flat[0 +: PW] : '0);
    end else begin : g_no_mirror
      assign mix_flat[p*PW +: PW] = src_flat[p*PW +: PW];
    end

`ifdef AUTOFIRE_EN
    if (NUM_BUTTONS >= 2) begin : g_af
      logic          held_q, held_d, phase_q, phase_d, phase_now;
      logic [PW-1:0] m, f;

      // Phase restarts high on each new press, then flips on counter wrap.
      always_comb begin
        m         = mix_flat[p*PW +: PW];
        held_d    = m[5];
        phase_now = (m[5] && !held_q) ? 1'b1 : phase_q;
        phase_d   = af_wrap ? ~phase_now : phase_now;
        f         = m;
        f[4]      = m[4] | (m[5] & phase_now);
        f[5]      = 1'b0;
      end

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          held_q  <= 1'b0;
          phase_q <= 1'b0;
        end else begin
          held_q  <= held_d;
          phase_q <= phase_d;
        end
      end

      assign fire_flat[p*PW +: PW] = f;
    end else begin : g_no_af
      assign fire_flat[p*PW +: PW] = mix_flat[p*PW +: PW];
    end
`else
    assign fire_flat[p*PW +: PW] = mix_flat[p*PW +: PW];
`endif

    logic [PW-1:0] rin, rout;
    assign rin = fire_flat[p*PW +: PW];

    // Direction bits: [3]=up [2]=down [1]=left [0]=right.
    always_comb begin
      rout = rin;
      if (rot_active) begin
        if (orientation[1]) begin
          rout[3] = rin[0];
          rout[0] = rin[2];
          rout[2] = rin[1];
          rout[1] = rin[3];
        end else begin
          rout[3] = rin[1];
          rout[1] = rin[2];
          rout[2] = rin[0];
          rout[0] = rin[3];
        end
      end
    end

    assign rot_flat[p*PW +: PW] = rout;

    coin_state_t   st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          raw_prev_q, coin_d;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
        COIN_IDLE: begin
          if (raw_coin[p] && !raw_prev_q) begin
            st_d  = COIN_PULSE;
            cnt_d = '0;
          end
        end
        COIN_PULSE: begin
          if (cnt_q == C_LAST) st_d = COIN_IDLE;
          else                 cnt_d = cnt_q + CW'(1);
        end
        default: st_d = COIN_IDLE;
      endcase
      coin_d = (st_d == COIN_PULSE);
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        st_q       <= COIN_IDLE;
        cnt_q      <= '0;
        raw_prev_q <= 1'b0;
        coin_q[p]  <= 1'b0;
      end else begin
        st_q       <= st_d;
        cnt_q      <= cnt_d;
        raw_prev_q <= raw_coin[p];
        coin_q[p]  <= coin_d;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      player_q <= '0;
      start_q  <= '0;
      tilt_q   <= 1'b0;
    end else begin
      player_q <= rot_flat;
      start_q  <= start_d;
      tilt_q   <= key_q[K_TILT];
    end
  end

  assign player = player_q;
  assign start  = start_q;
  assign tilt   = tilt_q;
  assign coin   = coin_q;

endmodule
`default_nettype wire

// File: tb/tb_arcade_controls_mp.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for arcade_controls_mp: directed steps, scoreboard queue of expected
// output words {tilt,start,coin,player}, immediate-assertion comparisons.
module tb_arcade_controls_mp;

  localparam int NP = 2;
  localparam int NB = 6;
  localparam int W  = NP * (4 + NB);

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          key_strobe, key_pressed, key_extended;
  logic [7:0]    key_code;
  logic [W-1:0]  joy_in;
  logic          rotate, joyswap, oneplayer;
  logic [1:0]    orientation;
  logic [NP-1:0] coin, start;
  logic          tilt;
  logic [W-1:0]  player;

  arcade_controls_mp #(
    .NUM_PLAYERS(NP),
    .NUM_BUTTONS(NB),
    .COIN_CYCLES(8)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .key_strobe  (key_strobe),
    .key_pressed (key_pressed),
    .key_extended(key_extended),
    .key_code    (key_code),
    .joy_in      (joy_in),
    .rotate      (rotate),
    .orientation (orientation),
    .joyswap     (joyswap),
    .oneplayer   (oneplayer),
    .coin        (coin),
    .start       (start),
    .tilt        (tilt),
    .player      (player)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  function automatic logic [31:0] outs();
    return {7'd0, tilt, start, coin, player};
  endfunction

  function automatic logic [31:0] ev(input logic [19:0] p, input logic [1:0] c,
                                     input logic [1:0] s, input logic t);
    return {7'd0, t, s, c, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] e);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] e);
    sb_t it;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic pop_check();
    sb_t it;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      it = sb_q.pop_front();
      check(it.tag, outs(), it.exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] e);
    push(tag, e);
    pop_check();
  endtask

  task automatic expect_next(input string tag, input logic [31:0] e);
    push(tag, e);
    tick();
    pop_check();
  endtask

  task automatic send_key(input logic ext, input logic [7:0] code, input logic mk);
    key_strobe   = 1'b1;
    key_extended = ext;
    key_code     = code;
    key_pressed  = mk;
    tick();
    key_strobe   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int high_cnt;
    int rises;
    logic prev;

    reset = 1'b1; key_strobe = 1'b0; key_pressed = 1'b0; key_extended = 1'b0;
    key_code = 8'h00; joy_in = '0; rotate = 1'b0; orientation = 2'b00;
    joyswap = 1'b0; oneplayer = 1'b0;
    tick(); tick();
    reset = 1'b0;
    expect_now("reset_state", 32'd0);

    // Keyboard: two-cycle latency and mapping
    send_key(1'b1, 8'h75, 1'b1);
    expect_now("up_latency", 32'd0);
    expect_next("p1_up_key", ev(20'h00008, 2'b00, 2'b00, 1'b0));
    send_key(1'b1, 8'h75, 1'b0);
    expect_next("p1_up_break", 32'd0);
    send_key(1'b0, 8'h75, 1'b1);
    expect_next("unmapped_code", 32'd0);
    send_key(1'b0, 8'h22, 1'b1);
    expect_next("p1_fireF", ev(20'h00200, 2'b00, 2'b00, 1'b0));
    send_key(1'b0, 8'h22, 1'b0);
    send_key(1'b0, 8'h2D, 1'b1);
    expect_next("p2_up_key", ev(20'h02000, 2'b00, 2'b00, 1'b0));
    send_key(1'b0, 8'h2D, 1'b0);
    send_key(1'b0, 8'h1B, 1'b1);
    expect_next("p2_fireB", ev(20'h08000, 2'b00, 2'b00, 1'b0));
    send_key(1'b0, 8'h1B, 1'b0);
    send_key(1'b0, 8'h16, 1'b1);
    send_key(1'b0, 8'h1E, 1'b1);
    expect_next("start_both", ev(20'h0, 2'b00, 2'b11, 1'b0));
    send_key(1'b0, 8'h16, 1'b0);
    send_key(1'b0, 8'h1E, 1'b0);
    send_key(1'b0, 8'h2C, 1'b1);
    expect_next("tilt", ev(20'h0, 2'b00, 2'b00, 1'b1));
    send_key(1'b0, 8'h2C, 1'b0);
    expect_next("all_released", 32'd0);

    // Joystick and rotation
    joy_in = 20'h00001;
    expect_next("joy_right", ev(20'h00001, 2'b00, 2'b00, 1'b0));
    rotate = 1'b1; orientation = 2'b11;
    expect_next("rot_cw", ev(20'h00008, 2'b00, 2'b00, 1'b0));
    orientation = 2'b01;
    expect_next("rot_ccw", ev(20'h00004, 2'b00, 2'b00, 1'b0));
    orientation = 2'b00;
    expect_next("rot_horizontal", ev(20'h00001, 2'b00, 2'b00, 1'b0));
    orientation = 2'b11; joy_in = 20'h02010;
    expect_next("rot_p2_fire", ev(20'h00810, 2'b00, 2'b00, 1'b0));
    orientation = 2'b01; joy_in = 20'h00008;
    expect_next("rot_ccw_up", ev(20'h00001, 2'b00, 2'b00, 1'b0));
    rotate = 1'b0; joy_in = '0;

    // Single-player mirror and joystick swap
    oneplayer = 1'b1; joy_in = 20'h00010;
    expect_next("oneplayer", ev(20'h04010, 2'b00, 2'b00, 1'b0));
    oneplayer = 1'b0;
    expect_next("oneplayer_off", ev(20'h00010, 2'b00, 2'b00, 1'b0));
    joy_in = 20'h00800; joyswap = 1'b1;
    expect_next("joyswap", ev(20'h00002, 2'b00, 2'b00, 1'b0));
    joyswap = 1'b0;
    expect_next("no_swap", ev(20'h00800, 2'b00, 2'b00, 1'b0));
    joy_in = 20'h00001;
    send_key(1'b1, 8'h75, 1'b1);
    expect_next("joy_key_or", ev(20'h00009, 2'b00, 2'b00, 1'b0));
    send_key(1'b1, 8'h75, 1'b0);
    joy_in = '0;
    tick();

    // Coin shaping: held key, break/make inside the pulse ignored
    send_key(1'b0, 8'h2E, 1'b1);
    expect_now("coin_latency", 32'd0);
    high_cnt = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 3) begin
        key_strobe = 1'b1; key_extended = 1'b0; key_code = 8'h2E; key_pressed = 1'b0;
      end
      if (i == 4) begin
        key_strobe = 1'b1; key_extended = 1'b0; key_code = 8'h2E; key_pressed = 1'b1;
      end
      tick();
      key_strobe = 1'b0;
      if (i == 0) check("coin_first_cycle", {31'd0, coin[0]}, 32'd1);
      if (coin[0]) high_cnt++;
      if (coin[0] && !prev) rises++;
      prev = coin[0];
    end
    check("coin_high_cycles", high_cnt, 32'd8);
    check("coin_pulse_count", rises, 32'd1);
    send_key(1'b0, 8'h2E, 1'b0);
    send_key(1'b0, 8'h36, 1'b1);
    expect_next("coin2", ev(20'h0, 2'b10, 2'b00, 1'b0));
    send_key(1'b0, 8'h36, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    expect_now("coin2_done", 32'd0);

    // Reset in mid-pulse truncates it and clears key state
    send_key(1'b1, 8'h75, 1'b1);
    send_key(1'b0, 8'h2E, 1'b1);
    tick(); tick(); tick();
    expect_now("pulse_cycle3", ev(20'h00008, 2'b01, 2'b00, 1'b0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_now("reset_mid_pulse", 32'd0);
    expect_next("keys_cleared", 32'd0);
    send_key(1'b0, 8'h2E, 1'b1);
    high_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (coin[0]) high_cnt++;
    end
    check("coin_after_reset", high_cnt, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
